// File: rtl/sensor_monitor_multi.sv
// ============================================================================
// sensor_monitor_multi
//
// Plant sensor monitor: NUM_CH debounced active-low hazard channels with
// sticky alarm flags and acknowledge, a debounced IR object counter that
// saturates at COUNT_MAX, a pattern-driven buzzer and a motor interlock FSM
// with a timed restart.
//
// Optional feature macro: MOTOR_BRAKE_EN
//   defined   : STOP drives in1_o=1, in2_o=1 (dynamic brake)
//   undefined : STOP drives in1_o=0, in2_o=0 (coast)
//
// Ports:
//   clk_i            system clock
//   reset_i          asynchronous active-high reset, clears all state
//   ir_i             object sensor, active-low (0 = object present)
//   haz_n_i          hazard sensors, active-low (0 = hazard)
//   count_clr_i      synchronous clear of the object count
//   alarm_ack_i      acknowledge of latched alarms (level, sampled every clk)
//   count_o          object count
//   alarm_live_o     debounced hazard present, one bit per channel
//   alarm_latched_o  sticky alarm flags
//   buzzer_o         audible alarm
//   in1_o, in2_o     motor driver inputs
//   motor_state_o    FSM state: 0 = WAIT, 1 = RUN, 2 = STOP
// ============================================================================
module sensor_monitor_multi #(
    parameter int                NUM_CH         = 2,
    parameter int                TICK_DIV       = 25000000,
    parameter int                DEBOUNCE_TICKS = 3,
    parameter int                CNT_W          = 14,
    parameter int                COUNT_MAX      = 9999,
    parameter logic [NUM_CH-1:0] INTERLOCK_MASK = NUM_CH'(2'b10),
    parameter int                RESTART_TICKS  = 5
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              ir_i,
    input  logic [NUM_CH-1:0] haz_n_i,
    input  logic              count_clr_i,
    input  logic              alarm_ack_i,
    output logic [CNT_W-1:0]  count_o,
    output logic [NUM_CH-1:0] alarm_live_o,
    output logic [NUM_CH-1:0] alarm_latched_o,
    output logic              buzzer_o,
    output logic              in1_o,
    output logic              in2_o,
    output logic [1:0]        motor_state_o
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
    localparam int RW = $clog2(RESTART_TICKS + 1);
    // Input 0 is the IR sensor, inputs 1..NUM_CH are the hazard channels.
    localparam int NI = NUM_CH + 1;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Sample tick prescaler
    // ------------------------------------------------------------------
    logic [PW-1:0] presc_q, presc_d;
    logic          tick;

    assign tick    = (presc_q == PW'(TICK_DIV - 1));
    assign presc_d = tick ? '0 : presc_q + 1'b1;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) presc_q <= '0;
        else         presc_q <= presc_d;
    end

    // ------------------------------------------------------------------
    // Synchronisers and debouncers, one per input
    // ------------------------------------------------------------------
    logic [NI-1:0] raw_in;
    logic [NI-1:0] stable_vec;

    assign raw_in = {haz_n_i, ir_i};

    genvar gi;
    generate
        for (gi = 0; gi < NI; gi++) begin : g_in
            logic          sync1_q, sync2_q;
            logic          stable_q, stable_d;
            logic [DW-1:0] run_q, run_d;

            // Since the stable value is binary, every sample that differs
            // from it also agrees with the other differing samples, so a
            // run counter of mismatching samples is all that is needed.
            always_comb begin
                stable_d = stable_q;
                run_d    = run_q;
                if (tick) begin
                    if (sync2_q != stable_q) begin
                        if (run_q == DW'(DEBOUNCE_TICKS - 1)) begin
                            stable_d = sync2_q;
                            run_d    = '0;
                        end else begin
                            run_d = run_q + 1'b1;
                        end
                    end else begin
                        run_d = '0;
                    end
                end
            end

            // All inputs are active-low, so the idle level after reset is 1.
            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i) begin
                    sync1_q  <= 1'b1;
                    sync2_q  <= 1'b1;
                    stable_q <= 1'b1;
                    run_q    <= '0;
                end else begin
                    sync1_q  <= raw_in[gi];
                    sync2_q  <= sync1_q;
                    stable_q <= stable_d;
                    run_q    <= run_d;
                end
            end

            assign stable_vec[gi] = stable_q;
        end
    endgenerate

    logic ir_db;
    assign ir_db        = stable_vec[0];
    assign alarm_live_o = ~stable_vec[NUM_CH:1];

    // ------------------------------------------------------------------
    // Object counter: counts falling edges of the debounced IR input
    // ------------------------------------------------------------------
    logic             ir_prev_q;
    logic             ir_fall;
    logic [CNT_W-1:0] count_q, count_d;

    assign ir_fall = ir_prev_q & ~ir_db;

    always_comb begin
        count_d = count_q;
        if (count_clr_i) begin
            count_d = '0;
        end else if (ir_fall && (count_q != CNT_W'(COUNT_MAX))) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ir_prev_q <= 1'b1;
            count_q   <= '0;
        end else begin
            ir_prev_q <= ir_db;
            count_q   <= count_d;
        end
    end

    assign count_o = count_q;

    // ------------------------------------------------------------------
    // Latched alarms: set while live, cleared by ack once no longer live
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0] latched_q, latched_d;

    assign latched_d = alarm_live_o | (latched_q & ~{NUM_CH{alarm_ack_i}});

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) latched_q <= '0;
        else         latched_q <= latched_d;
    end

    assign alarm_latched_o = latched_q;

    // ------------------------------------------------------------------
    // Buzzer: steady while any hazard is live, chirps on tick while only
    // latched flags remain. The chirp phase is gated combinationally so
    // the buzzer drops in the same cycle the last latched flag clears.
    // ------------------------------------------------------------------
    logic any_live, any_latched;
    logic chirp_q, chirp_d;

    assign any_live    = |alarm_live_o;
    assign any_latched = |latched_q;

    always_comb begin
        chirp_d = 1'b0;
        if (any_live) begin
            chirp_d = 1'b1;          // continue seamlessly from steady-on
        end else if (any_latched) begin
            chirp_d = tick ? ~chirp_q : chirp_q;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) chirp_q <= 1'b0;
        else         chirp_q <= chirp_d;
    end

    assign buzzer_o = any_live | (any_latched & chirp_q);

    // ------------------------------------------------------------------
    // Motor interlock FSM
    // ------------------------------------------------------------------
    state_t        state_q, state_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          trip, hold;
    logic          in1_q, in1_d, in2_q, in2_d;

    assign trip = |(alarm_live_o & INTERLOCK_MASK);
    assign hold = |(latched_q & INTERLOCK_MASK);

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        case (state_q)
            ST_RUN: begin
                if (trip) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (!hold) begin
                    state_d = ST_WAIT;
                    rcnt_d  = '0;
                end
            end
            ST_WAIT: begin
                // A trip outranks a restart expiring in the same cycle.
                if (trip) begin
                    state_d = ST_STOP;
                end else if (tick) begin
                    if (rcnt_q == RW'(RESTART_TICKS - 1)) begin
                        state_d = ST_RUN;
                        rcnt_d  = '0;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_WAIT;
                rcnt_d  = '0;
            end
        endcase
    end

    // Driver pins follow the current state, so they lag it by one clk.
    always_comb begin
        in1_d = 1'b0;
        in2_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                in1_d = 1'b1;
            end
            ST_STOP: begin
`ifdef MOTOR_BRAKE_EN
                in1_d = 1'b1;
                in2_d = 1'b1;
`else
                in1_d = 1'b0;
                in2_d = 1'b0;
`endif
            end
            default: begin
                in1_d = 1'b0;
                in2_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_WAIT;
            rcnt_q  <= '0;
            in1_q   <= 1'b0;
            in2_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            in1_q   <= in1_d;
            in2_q   <= in2_d;
        end
    end

    assign in1_o         = in1_q;
    assign in2_o         = in2_q;
    assign motor_state_o = state_q;

endmodule

// File: tb/tb_sensor_monitor_multi.sv
// Directed bench for sensor_monitor_multi with TICK_DIV=4, DEBOUNCE_TICKS=3,
// RESTART_TICKS=5, NUM_CH=2, INTERLOCK_MASK=2'b10, CNT_W=4, COUNT_MAX=9.
module tb_sensor_monitor_multi;

    localparam int CNT_W = 4;
`ifdef MOTOR_BRAKE_EN
    localparam logic STOP_IN1 = 1'b1;
    localparam logic STOP_IN2 = 1'b1;
`else
    localparam logic STOP_IN1 = 1'b0;
    localparam logic STOP_IN2 = 1'b0;
`endif

    logic             clk;
    logic             reset;
    logic             ir;
    logic [1:0]       haz_n;
    logic             count_clr;
    logic             alarm_ack;
    logic [CNT_W-1:0] count;
    logic [1:0]       alarm_live;
    logic [1:0]       alarm_latched;
    logic             buzzer;
    logic             in1;
    logic             in2;
    logic [1:0]       motor_state;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    sensor_monitor_multi #(
        .NUM_CH         (2),
        .TICK_DIV       (4),
        .DEBOUNCE_TICKS (3),
        .CNT_W          (CNT_W),
        .COUNT_MAX      (9),
        .INTERLOCK_MASK (2'b10),
        .RESTART_TICKS  (5)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .ir_i            (ir),
        .haz_n_i         (haz_n),
        .count_clr_i     (count_clr),
        .alarm_ack_i     (alarm_ack),
        .count_o         (count),
        .alarm_live_o    (alarm_live),
        .alarm_latched_o (alarm_latched),
        .buzzer_o        (buzzer),
        .in1_o           (in1),
        .in2_o           (in2),
        .motor_state_o   (motor_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Posedges since reset release; the prescaler value equals cyc % 4.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic align_phase(input int ph);
        for (int i = 0; i < 4; i++) begin
            if ((cyc % 4) != ph) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; ir = 1'b1; haz_n = 2'b11; count_clr = 1'b0; alarm_ack = 1'b0;
        wait_clk(3);
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_checks++; if (alarm_live !== 2'b00) begin n_fail++; $display("FAIL reset_live: got %b expected 00", alarm_live); end
        n_checks++; if (alarm_latched !== 2'b00) begin n_fail++; $display("FAIL reset_latched: got %b expected 00", alarm_latched); end
        n_checks++; if (buzzer !== 1'b0) begin n_fail++; $display("FAIL reset_buzzer: got %b expected 0", buzzer); end
        n_checks++; if ({in1, in2} !== 2'b00) begin n_fail++; $display("FAIL reset_in: got %b expected 00", {in1, in2}); end
        n_checks++; if (motor_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", motor_state); end
        reset = 1'b0;
        wait_clk(1);
        n_checks++; if (motor_state !== 2'd0) begin n_fail++; $display("FAIL post_reset_state: got %0d expected 0", motor_state); end
        $display("reset: released, motor_state=%0d", motor_state);
    endtask

    task automatic test_motor_start();
        wait_clk(14);   // 15 posedges since release: only 3 ticks seen
        n_checks++; if (motor_state !== 2'd0) begin n_fail++; $display("FAIL start_still_wait: got %0d expected 0", motor_state); end
        wait_clk(9);    // 24 posedges: 5 ticks done, outputs settled
        n_checks++; if (motor_state !== 2'd1) begin n_fail++; $display("FAIL start_run: got %0d expected 1", motor_state); end
        n_checks++; if ({in1, in2} !== 2'b10) begin n_fail++; $display("FAIL start_in: got %b expected 10", {in1, in2}); end
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL start_count: got %0d expected 0", count); end
        n_checks++; if (buzzer !== 1'b0) begin n_fail++; $display("FAIL start_buzzer: got %b expected 0", buzzer); end
        $display("motor_start: state=%0d in1=%b in2=%b", motor_state, in1, in2);
    endtask

    task automatic test_glitch();
        ir = 1'b0; wait_clk(8);
        ir = 1'b1; wait_clk(40);
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL glitch_count: got %0d expected 0", count); end
        $display("glitch: count=%0d", count);
    endtask

    task automatic test_count();
        for (int i = 0; i < 4; i++) begin
            ir = 1'b0; wait_clk(40);
            n_checks++; if (count !== CNT_W'(i + 1)) begin n_fail++; $display("FAIL count_low_%0d: got %0d expected %0d", i, count, i + 1); end
            ir = 1'b1; wait_clk(40);
            n_checks++; if (count !== CNT_W'(i + 1)) begin n_fail++; $display("FAIL count_high_%0d: got %0d expected %0d", i, count, i + 1); end
            $display("count pulse %0d: count=%0d", i, count);
        end
    endtask

    task automatic test_saturate();
        int exp_c;
        for (int k = 1; k <= 8; k++) begin
            exp_c = (4 + k > 9) ? 9 : 4 + k;
            ir = 1'b0; wait_clk(40);
            n_checks++; if (count !== CNT_W'(exp_c)) begin n_fail++; $display("FAIL saturate_%0d: got %0d expected %0d", k, count, exp_c); end
            ir = 1'b1; wait_clk(40);
            $display("saturate pulse %0d: count=%0d", k, count);
        end
    endtask

    task automatic test_clear_priority();
        count_clr = 1'b1; wait_clk(1); count_clr = 1'b0;
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL clr_plain: got %0d expected 0", count); end
        // ir drops before posedge m+1 (m%4==1); debounced edge increments at m+12.
        align_phase(1);
        ir = 1'b0;
        wait_clk(11);
        count_clr = 1'b1; wait_clk(1); count_clr = 1'b0;
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL clr_vs_edge: got %0d expected 0", count); end
        wait_clk(30);
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL clr_after_edge: got %0d expected 0", count); end
        ir = 1'b1; wait_clk(40);
        ir = 1'b0; wait_clk(40);
        n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL count_after_clr: got %0d expected 1", count); end
        ir = 1'b1; wait_clk(40);
        $display("clear: count=%0d", count);
    endtask

    task automatic test_hazard_interlock();
        logic b0, bm, b1;
        haz_n = 2'b01; wait_clk(40);
        n_checks++; if (alarm_live !== 2'b10) begin n_fail++; $display("FAIL haz1_live: got %b expected 10", alarm_live); end
        n_checks++; if (alarm_latched !== 2'b10) begin n_fail++; $display("FAIL haz1_latched: got %b expected 10", alarm_latched); end
        n_checks++; if (buzzer !== 1'b1) begin n_fail++; $display("FAIL haz1_buzzer: got %b expected 1", buzzer); end
        n_checks++; if (motor_state !== 2'd2) begin n_fail++; $display("FAIL haz1_state: got %0d expected 2", motor_state); end
        n_checks++; if ({in1, in2} !== {STOP_IN1, STOP_IN2}) begin n_fail++; $display("FAIL haz1_in: got %b expected %b", {in1, in2}, {STOP_IN1, STOP_IN2}); end
        haz_n = 2'b11; wait_clk(40);
        n_checks++; if (alarm_live !== 2'b00) begin n_fail++; $display("FAIL rel_live: got %b expected 00", alarm_live); end
        n_checks++; if (alarm_latched !== 2'b10) begin n_fail++; $display("FAIL rel_latched: got %b expected 10", alarm_latched); end
        n_checks++; if (motor_state !== 2'd2) begin n_fail++; $display("FAIL rel_state: got %0d expected 2", motor_state); end
        // Chirp toggles at posedges where cyc becomes a multiple of 4.
        align_phase(1); b0 = buzzer;
        wait_clk(2);    bm = buzzer;
        wait_clk(2);    b1 = buzzer;
        n_checks++; if (bm !== b0) begin n_fail++; $display("FAIL chirp_mid: got %b expected %b", bm, b0); end
        n_checks++; if (b1 !== ~b0) begin n_fail++; $display("FAIL chirp_toggle: got %b expected %b", b1, ~b0); end
        alarm_ack = 1'b1; wait_clk(1); alarm_ack = 1'b0;
        n_checks++; if (alarm_latched !== 2'b00) begin n_fail++; $display("FAIL ack_latched: got %b expected 00", alarm_latched); end
        n_checks++; if (buzzer !== 1'b0) begin n_fail++; $display("FAIL ack_buzzer: got %b expected 0", buzzer); end
        wait_clk(1);
        n_checks++; if (motor_state !== 2'd0) begin n_fail++; $display("FAIL ack_wait: got %0d expected 0", motor_state); end
        wait_clk(28);
        n_checks++; if (motor_state !== 2'd1) begin n_fail++; $display("FAIL restart_run: got %0d expected 1", motor_state); end
        n_checks++; if ({in1, in2} !== 2'b10) begin n_fail++; $display("FAIL restart_in: got %b expected 10", {in1, in2}); end
        $display("hazard_interlock: chirp %b/%b/%b state=%0d", b0, bm, b1, motor_state);
    endtask

    task automatic test_non_interlock();
        haz_n = 2'b10; wait_clk(40);
        n_checks++; if (alarm_live !== 2'b01) begin n_fail++; $display("FAIL haz0_live: got %b expected 01", alarm_live); end
        n_checks++; if (alarm_latched !== 2'b01) begin n_fail++; $display("FAIL haz0_latched: got %b expected 01", alarm_latched); end
        n_checks++; if (buzzer !== 1'b1) begin n_fail++; $display("FAIL haz0_buzzer: got %b expected 1", buzzer); end
        n_checks++; if (motor_state !== 2'd1) begin n_fail++; $display("FAIL haz0_state: got %0d expected 1", motor_state); end
        alarm_ack = 1'b1; wait_clk(1); alarm_ack = 1'b0;
        n_checks++; if (alarm_latched !== 2'b01) begin n_fail++; $display("FAIL ack_while_live: got %b expected 01", alarm_latched); end
        haz_n = 2'b11; wait_clk(40);
        alarm_ack = 1'b1; wait_clk(1); alarm_ack = 1'b0;
        n_checks++; if (alarm_latched !== 2'b00) begin n_fail++; $display("FAIL haz0_cleared: got %b expected 00", alarm_latched); end
        n_checks++; if (motor_state !== 2'd1) begin n_fail++; $display("FAIL haz0_run: got %0d expected 1", motor_state); end
        $display("non_interlock: latched=%b state=%0d", alarm_latched, motor_state);
    endtask

    task automatic test_retrip_wait();
        logic seen_run, seen_wait;
        seen_run = 1'b0; seen_wait = 1'b0;
        haz_n = 2'b01; wait_clk(40);
        haz_n = 2'b11; wait_clk(40);
        // Hazard returns as the ack clears the latch: it debounces around the
        // third restart tick, before the fifth one could start the motor.
        alarm_ack = 1'b1; haz_n = 2'b01; wait_clk(1); alarm_ack = 1'b0;
        for (int i = 0; i < 40; i++) begin
            wait_clk(1);
            if (motor_state == 2'd1 || in1 == 1'b1 && !STOP_IN1) seen_run = 1'b1;
            if (motor_state == 2'd0) seen_wait = 1'b1;
        end
        n_checks++; if (seen_wait !== 1'b1) begin n_fail++; $display("FAIL retrip_wait_seen: got %b expected 1", seen_wait); end
        n_checks++; if (seen_run !== 1'b0) begin n_fail++; $display("FAIL retrip_run_glitch: got %b expected 0", seen_run); end
        n_checks++; if (motor_state !== 2'd2) begin n_fail++; $display("FAIL retrip_stop: got %0d expected 2", motor_state); end
        $display("retrip_wait: seen_wait=%b seen_run=%b state=%0d", seen_wait, seen_run, motor_state);
    endtask

    task automatic test_reset_mid_wait();
        haz_n = 2'b10; wait_clk(40);
        alarm_ack = 1'b1; wait_clk(1); alarm_ack = 1'b0;
        wait_clk(2);
        n_checks++; if (motor_state !== 2'd0) begin n_fail++; $display("FAIL pre_reset_wait: got %0d expected 0", motor_state); end
        n_checks++; if (alarm_live !== 2'b01) begin n_fail++; $display("FAIL pre_reset_live: got %b expected 01", alarm_live); end
        @(posedge clk); #2; reset = 1'b1; #1;
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL async_count: got %0d expected 0", count); end
        n_checks++; if (alarm_live !== 2'b00) begin n_fail++; $display("FAIL async_live: got %b expected 00", alarm_live); end
        n_checks++; if (alarm_latched !== 2'b00) begin n_fail++; $display("FAIL async_latched: got %b expected 00", alarm_latched); end
        n_checks++; if (buzzer !== 1'b0) begin n_fail++; $display("FAIL async_buzzer: got %b expected 0", buzzer); end
        n_checks++; if ({in1, in2} !== 2'b00) begin n_fail++; $display("FAIL async_in: got %b expected 00", {in1, in2}); end
        n_checks++; if (motor_state !== 2'd0) begin n_fail++; $display("FAIL async_state: got %0d expected 0", motor_state); end
        $display("reset_mid_wait: count=%0d live=%b state=%0d", count, alarm_live, motor_state);
        wait_clk(2);
        haz_n = 2'b11; reset = 1'b0;
        wait_clk(2);
    endtask

    initial begin
        test_reset();
        test_motor_start();
        test_glitch();
        test_count();
        test_saturate();
        test_clear_priority();
        test_hazard_interlock();
        test_non_interlock();
        test_retrip_wait();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
